// File: rtl/cnn_pkg.sv
// Shared CNN channel types: sequencer FSM states, signed 4-bit weight type,
// and helpers for tap count / tap-index width.
package cnn_pkg;

   typedef enum logic [1:0] {
      S_NOKERNEL,
      S_ACCUM,
      S_HOLD
   } state_t;

   typedef logic signed [3:0] weight_t;

   localparam int unsigned WeightBits = 4;

   function automatic int unsigned taps(input int unsigned kernel_dim);
      return kernel_dim * kernel_dim;
   endfunction

   // A 1x1 kernel still needs a one-bit tap counter.
   function automatic int unsigned tap_width(input int unsigned kernel_dim);
      return (taps(kernel_dim) > 1) ? $clog2(taps(kernel_dim)) : 1;
   endfunction

endpackage

// File: rtl/multiply_4Bit.sv
// Signed BitSize x 4-bit multiplier: full 2*BitSize product, arithmetic
// right shift by FixedPointPos, truncated back to BitSize.
module multiply_4Bit
   import cnn_pkg::*;
#(
   parameter int unsigned BitSize       = 32,
   parameter int unsigned FixedPointPos = 0
) (
   input  logic [BitSize-1:0] i_data,
   input  weight_t            i_weight,
   output logic [BitSize-1:0] o_product
);

   logic signed [2*BitSize-1:0] data_ext;
   logic signed [2*BitSize-1:0] weight_ext;
   logic signed [2*BitSize-1:0] full;

   always_comb begin
      data_ext   = {{BitSize{i_data[BitSize-1]}}, i_data};
      weight_ext = {{(2*BitSize-WeightBits){i_weight[WeightBits-1]}}, i_weight};
      full       = data_ext * weight_ext;
   end

   assign o_product = BitSize'(full >>> FixedPointPos);

endmodule

// File: rtl/kernel_mac_sequencer.sv
// Sequences one shared 4-bit-weight multiplier over a KernelDim x KernelDim
// window and emits one accumulated result per window. Optional: RELU_EN.
module kernel_mac_sequencer
   import cnn_pkg::*;
#(
   parameter int unsigned BitSize       = 32,
   parameter int unsigned FixedPointPos = 0,
   parameter int unsigned KernelDim     = 3
) (
   input  logic                                   clk,
   input  logic                                   res_n,
   input  logic                                   i_load_kernel,
   input  logic [WeightBits*taps(KernelDim)-1:0]  i_kernel,
   input  logic                                   i_valid,
   input  logic [BitSize-1:0]                     i_data,
   output logic                                   o_ready,
   output logic                                   o_valid,
   output logic [BitSize-1:0]                     o_data,
   input  logic                                   i_out_ready,
   output logic                                   o_busy
);

   localparam int unsigned Taps = taps(KernelDim);
   localparam int unsigned TapW = tap_width(KernelDim);
   localparam logic [TapW-1:0] LastTap = TapW'(Taps - 1);

   state_t                    state;
   weight_t [Taps-1:0]        weights;
   logic    [TapW-1:0]        tap;
   logic    [BitSize-1:0]     acc;
   weight_t                   cur_weight;
   logic    [BitSize-1:0]     product;
   logic    [BitSize-1:0]     sum;
   logic    [BitSize-1:0]     result;

   assign cur_weight = weights[tap];

   multiply_4Bit #(
      .BitSize       (BitSize),
      .FixedPointPos (FixedPointPos)
   ) u_mult (
      .i_data    (i_data),
      .i_weight  (cur_weight),
      .o_product (product)
   );

   assign sum = acc + product;

`ifdef RELU_EN
   assign result = sum[BitSize-1] ? '0 : sum;
`else
   assign result = sum;
`endif

   // A kernel load takes the cycle, so no sample is accepted alongside it.
   assign o_ready = (state == S_ACCUM) && !i_load_kernel;
   assign o_busy  = (tap != '0) || o_valid;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state   <= S_NOKERNEL;
         weights <= '0;
         tap     <= '0;
         acc     <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load_kernel) begin
         weights <= i_kernel;
         tap     <= '0;
         acc     <= '0;
         o_valid <= 1'b0;
         state   <= S_ACCUM;
      end else begin
         unique case (state)
            S_ACCUM: begin
               if (i_valid) begin
                  if (tap == LastTap) begin
                     o_data  <= result;
                     o_valid <= 1'b1;
                     tap     <= '0;
                     acc     <= '0;
                     state   <= S_HOLD;
                  end else begin
                     acc <= sum;
                     tap <= tap + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (i_out_ready) begin
                  o_valid <= 1'b0;
                  state   <= S_ACCUM;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
